control_ld: RTL and testbench
=============================

// Module: control_ld
// PURPOSE
//  Load-data extension unit in the core's memory-read path (LSU -> writeback mux).
//  Takes the 32-bit word already lane-aligned to bits [7:0]/[15:0] and produces the
//  architectural value for LB/LBU, LH/LHU and LW by sign- or zero-extension.
//  Primary result is purely combinational (same-cycle writeback).
//  A registered copy is provided for a pipelined writeback stage.
// PARAMETERS
//  XLEN      32   datapath width; only 32 is supported.
// PORTS
//  i_clk      in   1     single clock; rising edge; used only by the registered copy.
//  i_rst_n    in   1     reset; asynchronous, active-low.
//  i_data     in   32    raw load data, lane-aligned to LSB.
//  i_unsign   in   1     1 = zero-extend (LBU/LHU), 0 = sign-extend (LB/LH).
//  i_mask     in   4     byte-enable pattern giving access size.
//  o_data     out  32    extended result, combinational.
//  o_data_q   out  32    o_data registered on i_clk.
//  o_err      out  1     1 when i_mask is not a supported size encoding (combinational).
// BEHAVIOUR
//  - Size decode on i_mask, full 4-bit compare:
//    4'b0001 byte:  o_data = i_unsign ? {24'h0, i_data[7:0]}  : {{24{i_data[7]}},  i_data[7:0]}
//    4'b0011 half:  o_data = i_unsign ? {16'h0, i_data[15:0]} : {{16{i_data[15]}}, i_data[15:0]}
//    4'b1111 word:  o_data = i_data; i_unsign has no effect.
//    any other:     o_data = i_data (pass-through), o_err = 1.
//  - o_err = 0 for the three supported masks.
//  - Byte/half: bits above the selected field are ignored.
//  - Sign bit is bit 7 (byte) or bit 15 (half); 8'h7F / 16'h7FFF extend with zeros.
//  - o_data and o_err: zero-cycle latency; no state; glitch-free once inputs are stable.
//  - Neither output depends on i_clk or i_rst_n.
//  - o_data_q: updates to o_data at every i_clk rising edge (1-cycle latency).
//    Cleared to 32'h0 asynchronously while i_rst_n = 0.
//    Resumes capture on the first rising edge after i_rst_n deasserts.
//  - Reset values: o_data_q = 0.
//    o_data and o_err follow the inputs even during reset.
//  - No handshake; caller guarantees i_mask/i_unsign are consistent with the decoded load opcode.
//  - X on i_mask must not be masked.
//    Unknown mask -> o_data may be X; simulation assertion flags X on i_mask when i_rst_n = 1.
// STRUCTURE
//  - Shared package (core_pkg): localparams MASK_B = 4'b0001, MASK_H = 4'b0011,
//    MASK_W = 4'b1111; typedef logic [31:0] word_t.
//  - One sub-module natural: ld_ext_unit (combinational size/sign extension, o_data + o_err).
//  - Top adds the async-reset output register and X-check assertions.
// TESTING
//  1 Byte signed/unsigned, i_mask=0001:
//    i_data=32'hF4, unsign=0 -> FFFFFFF4; unsign=1 -> 000000F4.
//    i_data=32'h7F, unsign 0 or 1 -> 0000007F.
//  2 Half signed/unsigned, i_mask=0011:
//    i_data=32'h0000FFF4, unsign=0 -> FFFFFFF4; unsign=1 -> 0000FFF4.
//    i_data=32'h7FFF, unsign 0 or 1 -> 00007FFF.
//  3 Upper bits ignored, i_data=32'hFFFFFFFF:
//    mask 0001: unsign=0 -> FFFFFFFF, unsign=1 -> 000000FF.
//    mask 0011: unsign=0 -> FFFFFFFF, unsign=1 -> 0000FFFF.
//  4 Word, i_mask=1111:
//    AABBCCDD/unsign=0 -> AABBCCDD; 12345678/0 -> 12345678; 87654321/1 -> 87654321.
//    o_err=0 in all cases.
//  5 Illegal mask: i_mask=0100, i_data=DEADBEEF -> o_data=DEADBEEF, o_err=1.
//    Repeat with mask 0000 and 1100.
//  6 Register path: i_rst_n=0 -> o_data_q=0 immediately, no clock needed.
//    Release reset, drive case-1 input, one i_clk edge -> o_data_q=FFFFFFF4.
//    Assert i_rst_n mid-run -> o_data_q clears asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the load-data path.
// Access-size byte-enable encodings and the datapath word type.
package core_pkg;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/ld_ext_unit.sv
// Combinational load-data size decode and sign/zero extension.
// Unsupported masks pass the raw word through and raise o_err.
module ld_ext_unit
   import core_pkg::*;
(
   input  word_t      i_data,
   input  logic       i_unsign,
   input  logic [3:0] i_mask,
   output word_t      o_data,
   output logic       o_err
);

   // decode access size from the full mask and extend the selected field
   always_comb begin
      o_data = i_data;
      o_err  = 1'b0;
      case (i_mask)
         MASK_B: begin
            if (i_unsign)
               o_data = {24'h0, i_data[7:0]};
            else
               o_data = {{24{i_data[7]}}, i_data[7:0]};
         end
         MASK_H: begin
            if (i_unsign)
               o_data = {16'h0, i_data[15:0]};
            else
               o_data = {{16{i_data[15]}}, i_data[15:0]};
         end
         MASK_W: o_data = i_data;
         default: begin
            o_data = i_data;
            o_err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_ld.sv
// Load-data extension unit: same-cycle result plus a registered copy
// for a pipelined writeback stage.
module control_ld
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_data,
   input  logic            i_unsign,
   input  logic [3:0]      i_mask,
   output logic [XLEN-1:0] o_data,
   output logic [XLEN-1:0] o_data_q,
   output logic            o_err
);

   word_t data_d;
   word_t data_q;
   logic  err_d;

   ld_ext_unit u_ext (
      .i_data   (i_data),
      .i_unsign (i_unsign),
      .i_mask   (i_mask),
      .o_data   (data_d),
      .o_err    (err_d)
   );

   // capture the extended result each cycle; async clear on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         data_q <= '0;
      else
         data_q <= data_d;
   end

   assign o_data   = data_d;
   assign o_err    = err_d;
   assign o_data_q = data_q;

   // an unknown size encoding must never be silently decoded
   a_mask_known : assert property (
      @(posedge i_clk) disable iff (!i_rst_n) !$isunknown(i_mask)
   ) else $error("control_ld: X on i_mask");

endmodule

// File: tb/tb_control_ld.sv
// Scoreboard bench for control_ld.
// Directed load cases, then random traffic against a reference model.
module tb_control_ld;

   logic        clk;
   logic        rst_n;
   logic [31:0] data;
   logic        uns;
   logic [3:0]  mask;
   logic [31:0] o_data;
   logic [31:0] o_data_q;
   logic        o_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
      logic [31:0] q;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prev_exp;

   control_ld #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_data   (data),
      .i_unsign (uns),
      .i_mask   (mask),
      .o_data   (o_data),
      .o_data_q (o_data_q),
      .o_err    (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // reference: load semantics as plain arithmetic on the field value
   function automatic logic [32:0] ref_model(input logic [31:0] d,
                                             input logic u,
                                             input logic [3:0] m);
      longint v;
      logic [31:0] r;
      if (m == 4'd1) begin
         v = longint'(d) % 256;
         if (!u && v >= 128) v = v - 256;
         r = 32'(v);
         return {1'b0, r};
      end else if (m == 4'd3) begin
         v = longint'(d) % 65536;
         if (!u && v >= 32768) v = v - 65536;
         r = 32'(v);
         return {1'b0, r};
      end else if (m == 4'd15) begin
         return {1'b0, d};
      end
      return {1'b1, d};
   endfunction

   // drive one cycle of stimulus and queue its expected responses
   task automatic drive(input logic [31:0] d, input logic u,
                        input logic [3:0] m);
      exp_t        e;
      logic [32:0] r;
      @(posedge clk);
      #1;
      e.q = rst_n ? prev_exp : 32'h0;
      data = d;
      uns  = u;
      mask = m;
      r    = ref_model(d, u, m);
      e.d  = r[31:0];
      e.e  = r[32];
      prev_exp = r[31:0];
      sb.push_back(e);
   endtask

   // monitor: compare DUT outputs mid-cycle against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("o_data", o_data, e.d);
         check("o_err", {31'h0, o_err}, {31'h0, e.e});
         check("o_data_q", o_data_q, e.q);
      end
   end

   initial begin
      logic [3:0] rm;
      int         wait_cyc;
      rst_n    = 1'b0;
      data     = 32'hF4;
      uns      = 1'b0;
      mask     = 4'b0001;
      prev_exp = 32'h0;
      #2;
      check("rst_q_noclk", o_data_q, 32'h0);
      check("rst_comb", o_data, 32'hFFFFFFF4);
      drive(32'h7F, 1'b0, 4'b0001);
      drive(32'h7F, 1'b1, 4'b0001);
      #6 rst_n = 1'b1;
      drive(32'hF4, 1'b0, 4'b0001);
      drive(32'hF4, 1'b1, 4'b0001);
      drive(32'h0000FFF4, 1'b0, 4'b0011);
      drive(32'h0000FFF4, 1'b1, 4'b0011);
      drive(32'h7FFF, 1'b0, 4'b0011);
      drive(32'h7FFF, 1'b1, 4'b0011);
      drive(32'hFFFFFFFF, 1'b0, 4'b0001);
      drive(32'hFFFFFFFF, 1'b1, 4'b0001);
      drive(32'hFFFFFFFF, 1'b0, 4'b0011);
      drive(32'hFFFFFFFF, 1'b1, 4'b0011);
      drive(32'hAABBCCDD, 1'b0, 4'b1111);
      drive(32'h12345678, 1'b0, 4'b1111);
      drive(32'h87654321, 1'b1, 4'b1111);
      drive(32'hDEADBEEF, 1'b0, 4'b0100);
      drive(32'hDEADBEEF, 1'b1, 4'b0000);
      drive(32'hDEADBEEF, 1'b0, 4'b1100);
      drive(32'hF4, 1'b0, 4'b0001);
      drive(32'h1234, 1'b1, 4'b0011);
      #6 rst_n = 1'b0;
      #1;
      check("rst_q_async", o_data_q, 32'h0);
      drive(32'h80, 1'b0, 4'b0001);
      drive(32'h8000, 1'b0, 4'b0011);
      #6 rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: rm = 4'b0001;
            1: rm = 4'b0011;
            2: rm = 4'b1111;
            default: rm = 4'($urandom);
         endcase
         drive($urandom, 1'($urandom), rm);
      end
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
